// File: rtl/chnl_rx_stream_pkg.sv
// ============================================================================
//  Module   : chnl_rx_stream_pkg
//  Purpose  : Shared definitions for the channel RX stream adapter:
//             controller state encoding and helpers that derive the
//             words-per-beat count and the FIFO entry width from the
//             data path width.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package chnl_rx_stream_pkg;

    localparam int unsigned WORD_BITS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_RECV = 2'd2
    } rx_state_t;

    // 32-bit words carried by one data beat
    function automatic int unsigned words_per_beat(input int unsigned width);
        return width / WORD_BITS;
    endfunction

    // log2 of the words-per-beat count (exact for power-of-two widths)
    function automatic int unsigned words_per_beat_log2(input int unsigned width);
        return $clog2(width / WORD_BITS);
    endfunction

    // FIFO entry layout is {last, keep[N-1:0], data[W-1:0]}
    function automatic int unsigned entry_width(input int unsigned width);
        return width + (width / WORD_BITS) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/chnl_rx_stream_if.sv
// ============================================================================
//  Module   : chnl_rx_stream_if
//  Purpose  : Bundles the channel RX handshake (host side) and the
//             valid/ready output stream (downstream side) of the adapter.
//  Modports : slave  - the adapter (consumes CHNL_RX_*, drives dout_*)
//             master - the environment (drives CHNL_RX_*, consumes dout_*)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface chnl_rx_stream_if
    import chnl_rx_stream_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 128
);
    localparam int N = int'(words_per_beat(C_PCI_DATA_WIDTH));

    logic                        CHNL_RX_CLK;
    logic                        CHNL_RX;
    logic                        CHNL_RX_ACK;
    logic                        CHNL_RX_LAST;
    logic [31:0]                 CHNL_RX_LEN;
    logic [30:0]                 CHNL_RX_OFF;
    logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA;
    logic                        CHNL_RX_DATA_VALID;
    logic                        CHNL_RX_DATA_REN;

    logic [C_PCI_DATA_WIDTH-1:0] dout;
    logic [N-1:0]                dout_keep;
    logic                        dout_last;
    logic                        dout_valid;
    logic                        dout_ready;

    modport slave (
        output CHNL_RX_CLK, CHNL_RX_ACK, CHNL_RX_DATA_REN,
        input  CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF,
        input  CHNL_RX_DATA, CHNL_RX_DATA_VALID,
        output dout, dout_keep, dout_last, dout_valid,
        input  dout_ready
    );

    modport master (
        input  CHNL_RX_CLK, CHNL_RX_ACK, CHNL_RX_DATA_REN,
        output CHNL_RX, CHNL_RX_LAST, CHNL_RX_LEN, CHNL_RX_OFF,
        output CHNL_RX_DATA, CHNL_RX_DATA_VALID,
        input  dout, dout_keep, dout_last, dout_valid,
        output dout_ready
    );

endinterface

`default_nettype wire

// File: rtl/chnl_rx_stream_fifo.sv
// ============================================================================
//  Module   : chnl_rx_fifo
//  Purpose  : SRL-style first-word-fall-through FIFO. New entries shift in
//             at index 0; the head is the oldest entry at index cnt-1, so a
//             write in cycle t is readable in cycle t+1.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             enq_i, din_i    - write strobe / data (ignored when full)
//             deq_i           - pop the head (ignored when empty)
//             dout_o          - head entry
//             emp_o, full_o   - exact empty / full flags
//             cnt_o           - current occupancy
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chnl_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 133
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  enq_i,
    input  wire logic [WIDTH-1:0]      din_i,
    input  wire logic                  deq_i,
    output logic      [WIDTH-1:0]      dout_o,
    output logic                       emp_o,
    output logic                       full_o,
    output logic      [DEPTH_LOG2:0]   cnt_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   c_full_cnt = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   c_cnt_one  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] c_idx_one  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2:0]   cnt_q;
    logic [DEPTH_LOG2:0]   cnt_d;
    logic                  w_enq;
    logic                  w_deq;
    logic [DEPTH_LOG2-1:0] w_rd_idx;

    assign emp_o  = (cnt_q == '0);
    assign full_o = (cnt_q == c_full_cnt);
    assign cnt_o  = cnt_q;

    assign w_enq = enq_i && !full_o;
    assign w_deq = deq_i && !emp_o;

    // When full the low bits are zero and the decrement wraps to DEPTH-1
    assign w_rd_idx = cnt_q[DEPTH_LOG2-1:0] - c_idx_one;
    assign dout_o   = mem_q[w_rd_idx];

    // Storage is a pure shift register and carries no reset
    always_ff @(posedge clk) begin
        if (w_enq) begin
            mem_q[0] <= din_i;
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({w_enq, w_deq})
            2'b10:   cnt_d = cnt_q + c_cnt_one;
            2'b01:   cnt_d = cnt_q - c_cnt_one;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/chnl_rx_stream.sv
// ============================================================================
//  Module   : chnl_rx_stream
//  Purpose  : RX front-end for one PCIe channel. Accepts a transaction,
//             acknowledges it for one cycle, counts incoming 32-bit words
//             against the announced length and buffers each beat with its
//             word-keep mask and last flag in a FWFT FIFO that feeds a
//             valid/ready stream.
//  Ports    : CLK, RST          - clock, synchronous active-high reset
//             rx (slave)        - channel RX handshake + output stream
//             xfer_len/off/host_last - fields latched at acceptance
//             busy              - controller not idle
//             stat_beats/stalls - statistics counters
//  Options  : CHNL_RX_STAT_EN   - when defined, stat_beats counts enqueued
//             beats and stat_stalls counts RECV cycles with VALID while
//             the FIFO is full (both saturating). Otherwise both read 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chnl_rx_stream
    import chnl_rx_stream_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 128,
    parameter int FIFO_SIZE        = 4
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    chnl_rx_stream_if.slave    rx,
    output logic [31:0]        xfer_len,
    output logic [30:0]        xfer_off,
    output logic               xfer_host_last,
    output logic               busy,
    output logic [31:0]        stat_beats,
    output logic [31:0]        stat_stalls
);

    localparam int N  = int'(words_per_beat(C_PCI_DATA_WIDTH));
    localparam int EW = int'(entry_width(C_PCI_DATA_WIDTH));
    localparam logic [32:0] c_n_words = 33'(N);

    rx_state_t   state_q;
    logic [31:0] len_q;
    logic [30:0] off_q;
    logic        host_last_q;
    logic [32:0] count_q;
    logic        ack_q;
    logic        busy_q;

    logic [32:0]    w_len_ext;
    logic [32:0]    w_rem;
    logic [32:0]    count_d;
    logic [N-1:0]   w_keep;
    logic           w_last;
    logic           w_ren;
    logic           w_enq;
    logic           w_full;
    logic           w_emp;
    logic [EW-1:0]  w_head;
    logic [FIFO_SIZE:0] w_unused_cnt;

    // Word count is one bit wider than LEN so count+N never wraps
    assign w_len_ext = {1'b0, len_q};
    assign w_rem     = w_len_ext - count_q;
    assign w_ren     = (state_q == ST_RECV) && (count_q < w_len_ext) && !w_full;
    assign w_enq     = rx.CHNL_RX_DATA_VALID && w_ren;
    assign count_d   = w_enq ? (count_q + c_n_words) : count_q;
    assign w_last    = (w_rem <= c_n_words);

    // Word i of the beat is valid while fewer than rem words precede it
    always_comb begin
        w_keep = '0;
        for (int i = 0; i < N; i++) begin
            w_keep[i] = (w_rem > 33'(i));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            off_q       <= '0;
            host_last_q <= 1'b0;
            count_q     <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx.CHNL_RX) begin
                        len_q       <= rx.CHNL_RX_LEN;
                        off_q       <= rx.CHNL_RX_OFF;
                        host_last_q <= rx.CHNL_RX_LAST;
                        count_q     <= '0;
                        ack_q       <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (len_q == '0) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    count_q <= count_d;
                    if (count_d >= w_len_ext) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    chnl_rx_fifo #(
        .DEPTH_LOG2 (FIFO_SIZE),
        .WIDTH      (EW)
    ) u_fifo (
        .clk    (CLK),
        .rst    (RST),
        .enq_i  (w_enq),
        .din_i  ({w_last, w_keep, rx.CHNL_RX_DATA}),
        .deq_i  (rx.dout_ready),
        .dout_o (w_head),
        .emp_o  (w_emp),
        .full_o (w_full),
        .cnt_o  (w_unused_cnt)
    );

    assign rx.CHNL_RX_CLK      = CLK;
    assign rx.CHNL_RX_ACK      = ack_q;
    assign rx.CHNL_RX_DATA_REN = w_ren;
    assign rx.dout             = w_head[C_PCI_DATA_WIDTH-1:0];
    assign rx.dout_keep        = w_head[C_PCI_DATA_WIDTH+N-1:C_PCI_DATA_WIDTH];
    assign rx.dout_last        = w_head[EW-1];
    assign rx.dout_valid       = !w_emp;

    assign xfer_len       = len_q;
    assign xfer_off       = off_q;
    assign xfer_host_last = host_last_q;
    assign busy           = busy_q;

`ifdef CHNL_RX_STAT_EN
    logic [31:0] beats_q;
    logic [31:0] stalls_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            beats_q  <= '0;
            stalls_q <= '0;
        end else begin
            if (w_enq && (beats_q != '1)) begin
                beats_q <= beats_q + 32'd1;
            end
            if ((state_q == ST_RECV) && rx.CHNL_RX_DATA_VALID && w_full
                    && (stalls_q != '1)) begin
                stalls_q <= stalls_q + 32'd1;
            end
        end
    end

    assign stat_beats  = beats_q;
    assign stat_stalls = stalls_q;
`else
    assign stat_beats  = '0;
    assign stat_stalls = '0;
`endif

endmodule

`default_nettype wire
